// File: rtl/anim_pkg.sv
// Shared types and default screen constants for the line animator.
// Coordinates are unsigned COORD_W-bit values feeding line_drawer.
package anim_pkg;

  localparam int COORD_W         = 11;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_STEP        = 4;
  localparam int DEF_HOLD_CYCLES = 5_000_000;

  typedef enum logic [3:0] {
    ST_CLR_START   = 4'd0,
    ST_CLR_WAIT    = 4'd1,
    ST_IDLE        = 4'd2,
    ST_DRAW_START  = 4'd3,
    ST_DRAW_WAIT   = 4'd4,
    ST_HOLD        = 4'd5,
    ST_ERASE_START = 4'd6,
    ST_ERASE_WAIT  = 4'd7,
    ST_MOVE        = 4'd8
  } anim_state_t;

  function automatic logic is_start_state(input anim_state_t s);
    return (s == ST_CLR_START) || (s == ST_DRAW_START) || (s == ST_ERASE_START);
  endfunction

  function automatic logic is_wait_state(input anim_state_t s);
    return (s == ST_CLR_WAIT) || (s == ST_DRAW_WAIT) || (s == ST_ERASE_WAIT);
  endfunction

endpackage

// File: rtl/line_animator_hold_timer.sv
// Loadable down-counter that times how long a drawn line stays on screen.
// The owner only enables it while the value is non-zero.
module hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] value_q, value_d;

  // next count: load wins over decrement
  always_comb begin
    if (load) begin
      value_d = load_value;
    end else if (en) begin
      value_d = value_q - W'(1);
    end else begin
      value_d = value_q;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == {W{1'b0}});

endmodule

// File: rtl/line_animator.sv
// Command sequencer for line_drawer: clears the screen row by row after reset,
// then sweeps a white line back and forth, holding and erasing it each frame.
module line_animator
  import anim_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int STEP        = DEF_STEP,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               done,
  output logic               start,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic               pixel_color,
  output logic               busy
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W:0]   X_MAX_W = (COORD_W + 1)'(SCREEN_W - 1);
  localparam logic [TW-1:0]      HOLD_LD = TW'(HOLD_CYCLES - 1);

  anim_state_t        state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d, pos_q, pos_d;
  logic               dir_q, dir_d, guard_q, guard_d;
  logic               start_q, start_d, color_q, color_d, busy_q, busy_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W:0]   pos_sum;
  logic               tmr_load, tmr_en, tmr_expired;
  logic [TW-1:0]      tmr_value;

  hold_timer #(.W(TW)) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .en         (tmr_en),
    .load_value (HOLD_LD),
    .value      (tmr_value),
    .expired    (tmr_expired)
  );

  // state transitions, sweep position update and registered command outputs
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    pos_sum  = {1'b0, pos_q} + {1'b0, STEP_C};
    case (state_q)
      // a START state leaves once its pulse has been presented to the drawer
      ST_CLR_START, ST_DRAW_START, ST_ERASE_START: begin
        if (start_q) begin
          state_d = anim_state_t'(state_q + 4'd1);
        end else begin
          state_d = state_q;
        end
      end
      ST_CLR_WAIT: begin
        if (guard_q && done) begin
          if (row_q == Y_MAX) begin
            row_d   = {COORD_W{1'b0}};
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + COORD_W'(1);
            state_d = ST_CLR_START;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_IDLE: begin
        if (go) begin
          state_d = ST_DRAW_START;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAW_WAIT: begin
        if (guard_q && done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (tmr_expired) begin
          state_d = ST_ERASE_START;
        end else begin
          state_d = state_q;
        end
      end
      ST_ERASE_WAIT: begin
        if (guard_q && done) begin
          state_d = ST_MOVE;
        end else begin
          state_d = state_q;
        end
      end
      ST_MOVE: begin
        if (dir_q) begin
          if (pos_sum > X_MAX_W) begin
            pos_d = X_MAX;
            dir_d = 1'b0;
          end else begin
            pos_d = pos_sum[COORD_W-1:0];
          end
        end else begin
          if (pos_q < STEP_C) begin
            pos_d = {COORD_W{1'b0}};
            dir_d = 1'b1;
          end else begin
            pos_d = pos_q - STEP_C;
          end
        end
        state_d = go ? ST_DRAW_START : ST_IDLE;
      end
      default: state_d = ST_CLR_START;
    endcase

    tmr_en = (state_q == ST_HOLD) && (tmr_value != {TW{1'b0}});
    // the guard is set only while remaining in the same WAIT state
    guard_d = is_wait_state(state_q) && (state_d == state_q);
    start_d = is_start_state(state_d);
    busy_d  = (state_d != ST_IDLE);

    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    if (start_d) begin
      if (state_d == ST_CLR_START) begin
        x0_d    = {COORD_W{1'b0}};
        y0_d    = row_d;
        x1_d    = X_MAX;
        y1_d    = row_d;
        color_d = 1'b0;
      end else begin
        x0_d    = pos_d;
        y0_d    = {COORD_W{1'b0}};
        x1_d    = X_MAX - pos_d;
        y1_d    = Y_MAX;
        color_d = (state_d == ST_DRAW_START);
      end
    end else begin
      color_d = color_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLR_START;
      row_q   <= {COORD_W{1'b0}};
      pos_q   <= {COORD_W{1'b0}};
      dir_q   <= 1'b1;
      guard_q <= 1'b0;
      start_q <= 1'b0;
      color_q <= 1'b0;
      busy_q  <= 1'b1;
      x0_q    <= {COORD_W{1'b0}};
      y0_q    <= {COORD_W{1'b0}};
      x1_q    <= {COORD_W{1'b0}};
      y1_q    <= {COORD_W{1'b0}};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      guard_q <= guard_d;
      start_q <= start_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
    end
  end

  assign start       = start_q;
  assign x0          = x0_q;
  assign y0          = y0_q;
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign pixel_color = color_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_line_animator.sv
// Scoreboard bench for line_animator on a 16x8 screen with a behavioural drawer.
// Expected start pulses (endpoints, colour, cycles since previous pulse) are queued.
module tb_line_animator;

  typedef struct {
    logic [10:0] x0, y0, x1, y1;
    logic        col;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        done;
  logic        start, pixel_color, busy;
  logic [10:0] x0, y0, x1, y1;
  logic        extra = 1'b0;
  int          dcnt;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_starts = 0;
  int   cyc = 0;
  int   last_start = 0;

  line_animator #(
    .SCREEN_W(16), .SCREEN_H(8), .STEP(4), .HOLD_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .done(done), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .pixel_color(pixel_color), .busy(busy)
  );

  always #5 clk = ~clk;

  // drawer model: done drops the cycle after start (two with extra), rises 5 cycles later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b1;
      dcnt <= 0;
    end else if (start) begin
      done <= extra ? 1'b1 : 1'b0;
      dcnt <= 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt + 1;
      if (dcnt == 1) done <= 1'b0;
      if (dcnt == (extra ? 6 : 5)) begin
        done <= 1'b1;
        dcnt <= 0;
      end
    end
  end

  task automatic push_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic c, input int gap);
    exp_t e;
    e.x0 = 11'(ax0); e.y0 = 11'(ay0); e.x1 = 11'(ax1); e.y1 = 11'(ay1);
    e.col = c; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_clear();
    for (int r = 0; r < 8; r++) push_line(0, r, 15, r, 1'b0, (r == 0) ? 0 : 7);
  endtask

  task automatic push_draw(input int p, input int gap);
    push_line(p, 0, 15 - p, 7, 1'b1, gap);
  endtask

  task automatic push_erase(input int p, input int gap);
    push_line(p, 0, 15 - p, 7, 1'b0, gap);
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    int   gap;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && start) begin
        gap = cyc - last_start;
        last_start = cyc;
        n_starts++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_start #%0d: got (%0d,%0d)-(%0d,%0d) c%0d, none expected",
                   n_starts, x0, y0, x1, y1, pixel_color);
        end else begin
          e = sb.pop_front();
          if (x0 !== e.x0 || y0 !== e.y0 || x1 !== e.x1 || y1 !== e.y1 ||
              pixel_color !== e.col || (e.gap != 0 && gap != e.gap)) begin
            miscompares++;
            $display("FAIL start#%0d: got (%0d,%0d)-(%0d,%0d) c%0d gap %0d, expected (%0d,%0d)-(%0d,%0d) c%0d gap %0d",
                     n_starts, x0, y0, x1, y1, pixel_color, gap,
                     e.x0, e.y0, e.x1, e.y1, e.col, e.gap);
          end
        end
      end
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int b = budget;
    while (n_starts < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (n_starts < n) check("start_timeout", n_starts, n);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    fork
      run_monitor();
    join_none

    // reset state and screen clear with go low
    idle_cycles(2);
    check("reset_busy", int'(busy), 1);
    check("reset_start", int'(start), 0);
    push_clear();
    reset = 1'b0;
    wait_starts(8, 200);
    idle_cycles(30);
    check("idle_after_clear_busy", int'(busy), 0);

    // continuous sweep: 0,4,8,12,15,11,7,3,0,4
    begin
      int seq[10] = '{0, 4, 8, 12, 15, 11, 7, 3, 0, 4};
      for (int i = 0; i < 10; i++) begin
        push_draw(seq[i], (i == 0) ? 0 : 8);
        push_erase(seq[i], 10);
      end
    end
    go = 1'b1;
    wait_starts(27, 400);
    // drop go while holding: the erase still happens, then idle
    idle_cycles(3);
    go = 1'b0;
    wait_starts(28, 100);
    idle_cycles(30);
    check("idle_after_drop_busy", int'(busy), 0);

    // MOVE advanced pos to 8; reset during DRAW_WAIT
    push_draw(8, 0);
    go = 1'b1;
    wait_starts(29, 100);
    idle_cycles(2);
    reset = 1'b1;
    #1;
    check("rst_start", int'(start), 0);
    check("rst_x0", int'(x0), 0);
    check("rst_x1", int'(x1), 0);
    check("rst_y1", int'(y1), 0);
    check("rst_color", int'(pixel_color), 0);
    check("rst_busy", int'(busy), 1);
    push_clear();
    push_draw(0, 8);
    push_erase(0, 10);
    idle_cycles(1);
    reset = 1'b0;
    wait_starts(38, 200);
    go = 1'b0;
    wait_starts(39, 100);
    idle_cycles(30);

    // done held high through the start cycle and the next one
    extra = 1'b1;
    push_draw(4, 0);
    push_erase(4, 11);
    go = 1'b1;
    wait_starts(40, 100);
    go = 1'b0;
    wait_starts(41, 100);
    idle_cycles(30);
    check("final_busy", int'(busy), 0);
    check("scoreboard_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
